// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package display_pkg;

  localparam int DIGIT_W = 5;
  localparam int SEG_W   = 7;

  typedef enum logic [1:0] {
    SCAN_IDLE  = 2'd0,
    SCAN_BLANK = 2'd1,
    SCAN_SHOW  = 2'd2
  } scan_state_e;

  // Bits needed to count 0..value-1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Per-digit slot counter; flags the end of the blank gap and the end of the slot.
module scan_slot_timer #(
  parameter int TICKS_PER_DIGIT = 50000,
  parameter int BLANK_TICKS     = 500,
  parameter int CNT_W           = display_pkg::clog2(TICKS_PER_DIGIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic blank_end,
  output logic slot_end
);
  import display_pkg::*;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(TICKS_PER_DIGIT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Slot counter: restarts whenever the controller begins a new slot or idles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign blank_end = (cnt_r == BLANK_LAST);
  assign slot_end  = (cnt_r == SLOT_LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed digit scan with blanking gaps and tear-free, frame-aligned value commit.
module display_scan_ctrl #(
  parameter int NUM_DIGITS      = 4,
  parameter int DIGIT_W         = display_pkg::DIGIT_W,
  parameter int TICKS_PER_DIGIT = 50000,
  parameter int BLANK_TICKS     = 500
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]  digit_val,
  output logic                           busy,
  output logic [DIGIT_W-1:0]             code_out,
  output logic [NUM_DIGITS-1:0]          dig_en,
  output logic                           frame_done
);
  import display_pkg::*;

  localparam int VAL_W = NUM_DIGITS * DIGIT_W;
  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  scan_state_e           state_r, state_nxt_s;
  logic [IDX_W-1:0]      idx_r, idx_nxt_s;
  logic [VAL_W-1:0]      pending_r, pending_nxt_s;
  logic [VAL_W-1:0]      shadow_r, shadow_nxt_s;
  logic                  busy_r, busy_nxt_s;
  logic [DIGIT_W-1:0]    code_r, code_nxt_s;
  logic [NUM_DIGITS-1:0] dig_en_r, dig_en_nxt_s;
  logic                  frame_done_r;
  logic                  wrap_s;
  logic                  clear_s;
  logic                  blank_end_s;
  logic                  slot_end_s;

  assign clear_s = (state_r == SCAN_IDLE) || !en || slot_end_s;

  scan_slot_timer #(
    .TICKS_PER_DIGIT (TICKS_PER_DIGIT),
    .BLANK_TICKS     (BLANK_TICKS)
  ) u_timer (
    .clk       (clk),
    .rst       (reset),
    .clear     (clear_s),
    .blank_end (blank_end_s),
    .slot_end  (slot_end_s)
  );

  // Scan sequencing: next state, next digit index and frame wrap detection.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    wrap_s      = 1'b0;
    case (state_r)
      SCAN_IDLE: begin
        idx_nxt_s = '0;
        if (en) begin
          state_nxt_s = SCAN_BLANK;
        end else begin
          state_nxt_s = SCAN_IDLE;
        end
      end
      SCAN_BLANK: begin
        if (!en) begin
          state_nxt_s = SCAN_IDLE;
          idx_nxt_s   = '0;
        end else if (blank_end_s) begin
          state_nxt_s = SCAN_SHOW;
        end else begin
          state_nxt_s = SCAN_BLANK;
        end
      end
      SCAN_SHOW: begin
        if (!en) begin
          state_nxt_s = SCAN_IDLE;
          idx_nxt_s   = '0;
        end else if (slot_end_s) begin
          state_nxt_s = SCAN_BLANK;
          if (idx_r == IDX_LAST) begin
            idx_nxt_s = '0;
            wrap_s    = 1'b1;
          end else begin
            idx_nxt_s = idx_r + IDX_W'(1);
          end
        end else begin
          state_nxt_s = SCAN_SHOW;
        end
      end
      default: begin
        state_nxt_s = SCAN_IDLE;
        idx_nxt_s   = '0;
      end
    endcase
  end

  // Load/commit handshake and next output values; outputs use post-commit data
  // so the first digit of a frame already shows the newly committed code.
  always_comb begin
    pending_nxt_s = pending_r;
    shadow_nxt_s  = shadow_r;
    busy_nxt_s    = busy_r;
    dig_en_nxt_s  = '0;
    if (wrap_s) begin
      busy_nxt_s = 1'b0;
      if (load) begin
        shadow_nxt_s  = digit_val;
        pending_nxt_s = digit_val;
      end else begin
        shadow_nxt_s = pending_r;
      end
    end else if (load) begin
      pending_nxt_s = digit_val;
      busy_nxt_s    = 1'b1;
    end else begin
      busy_nxt_s = busy_r;
    end
    code_nxt_s = shadow_nxt_s[idx_nxt_s*DIGIT_W +: DIGIT_W];
    if (state_nxt_s == SCAN_SHOW) begin
      dig_en_nxt_s[idx_nxt_s] = 1'b1;
    end else begin
      dig_en_nxt_s = '0;
    end
  end

  // State, data and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= SCAN_IDLE;
      idx_r        <= '0;
      pending_r    <= '0;
      shadow_r     <= '0;
      busy_r       <= 1'b0;
      code_r       <= '0;
      dig_en_r     <= '0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      idx_r        <= idx_nxt_s;
      pending_r    <= pending_nxt_s;
      shadow_r     <= shadow_nxt_s;
      busy_r       <= busy_nxt_s;
      code_r       <= code_nxt_s;
      dig_en_r     <= dig_en_nxt_s;
      frame_done_r <= wrap_s;
    end
  end

  assign busy       = busy_r;
  assign code_out   = code_r;
  assign dig_en     = dig_en_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: expected digit slots are queued as stimulus is planned.
module tb_display_scan_ctrl;

  localparam int ND  = 4;
  localparam int DW  = 5;
  localparam int TPD = 8;
  localparam int BT  = 2;

  localparam logic [19:0] V0 = {5'h03, 5'h02, 5'h01, 5'h00};
  localparam logic [19:0] V1 = {5'h1F, 5'h1E, 5'h1D, 5'h1C};
  localparam logic [19:0] VA = {5'h04, 5'h05, 5'h06, 5'h07};
  localparam logic [19:0] VB = {5'h0B, 5'h0A, 5'h09, 5'h08};
  localparam logic [19:0] VC = {5'h13, 5'h12, 5'h11, 5'h10};

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          load;
  logic [19:0]   digit_val;
  logic          busy;
  logic [4:0]    code_out;
  logic [3:0]    dig_en;
  logic          frame_done;

  typedef struct {
    logic [3:0] en;
    logic [4:0] code;
  } sb_item_t;

  sb_item_t exp_q[$];
  sb_item_t mon_it;
  logic [3:0] prev_en = 4'b0;
  int n_tests = 0;
  int n_fail  = 0;
  int k = 0;
  int first_en, zeros, fd_k, fd_cnt, bad_en, bad_fd;

  display_scan_ctrl #(
    .NUM_DIGITS      (ND),
    .DIGIT_W         (DW),
    .TICKS_PER_DIGIT (TPD),
    .BLANK_TICKS     (BT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load       (load),
    .digit_val  (digit_val),
    .busy       (busy),
    .code_out   (code_out),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, act, exp, k);
    end
  endtask

  function automatic void push_slots(input logic [19:0] val, input int first, input int last);
    sb_item_t it;
    for (int i = first; i <= last; i++) begin
      it.en   = 4'(1 << i);
      it.code = val[i*5 +: 5];
      exp_q.push_back(it);
    end
  endfunction

  // Scoreboard: each new enable window is compared against the next queued slot.
  always @(negedge clk) begin
    if (reset) begin
      prev_en = 4'b0;
    end else begin
      if (dig_en != 4'b0 && prev_en == 4'b0) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected", {28'b0, dig_en}, 32'h0);
        end else begin
          mon_it = exp_q.pop_front();
          check_eq("sb_en", {28'b0, dig_en}, {28'b0, mon_it.en});
          check_eq("sb_code", {27'b0, code_out}, {27'b0, mon_it.code});
        end
      end
      prev_en = dig_en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic sync0();
    @(posedge clk);
    #1;
    k = 0;
  endtask

  task automatic run_frame(output int f_en, output int zc, output int fk, output int fc);
    f_en = -1; zc = 0; fk = -1; fc = 0;
    repeat (32) begin
      tick();
      if (dig_en != 4'b0 && f_en < 0) f_en = k;
      if (dig_en == 4'b0) zc++;
      if (frame_done) begin
        fc++;
        fk = k;
      end
    end
  endtask

  task automatic wait_fd(input int exp_k);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (frame_done) found = 1'b1;
    end
    check_eq("fd_time", k, exp_k);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; digit_val = 20'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_dig_en", {28'b0, dig_en}, 32'h0);
    check_eq("rst_code", {27'b0, code_out}, 32'h0);
    check_eq("rst_busy", {31'b0, busy}, 32'h0);
    check_eq("rst_fd", {31'b0, frame_done}, 32'h0);
    @(negedge clk) reset = 1'b0;

    // 1: load in IDLE, then scan; first frame still shows reset codes
    @(negedge clk) begin load = 1'b1; digit_val = V0; end
    @(negedge clk) load = 1'b0;
    check_eq("t1_busy_set", {31'b0, busy}, 32'h1);
    push_slots(20'h0, 0, 3);
    push_slots(V0, 0, 3);
    en = 1'b1;
    sync0();
    run_frame(first_en, zeros, fd_k, fd_cnt);
    check_eq("t1_first_en", first_en, 2);
    check_eq("t1_blank_cycles", zeros, 8);
    check_eq("t1_fd_k", fd_k, 32);
    check_eq("t1_fd_count", fd_cnt, 1);
    check_eq("t1_busy_commit", {31'b0, busy}, 32'h0);

    // 2: mid-frame load waits for the wrap
    while (k < 40) tick();
    load = 1'b1; digit_val = V1;
    tick();
    load = 1'b0;
    check_eq("t2_busy_set", {31'b0, busy}, 32'h1);
    push_slots(V1, 0, 3);
    wait_fd(64);
    check_eq("t2_busy_clr", {31'b0, busy}, 32'h0);
    tick();
    check_eq("t2_fd_one_cycle", {31'b0, frame_done}, 32'h0);

    // 3: two loads in one frame, last wins
    while (k < 70) tick();
    load = 1'b1; digit_val = VA;
    tick();
    load = 1'b0;
    while (k < 80) tick();
    load = 1'b1; digit_val = VB;
    tick();
    load = 1'b0;
    check_eq("t3_busy_set", {31'b0, busy}, 32'h1);
    push_slots(VB, 0, 3);
    wait_fd(96);
    check_eq("t3_busy_clr", {31'b0, busy}, 32'h0);

    // 4: load in the exact commit cycle goes straight to shadow
    push_slots(VC, 0, 2);
    while (k < 127) tick();
    load = 1'b1; digit_val = VC;
    tick();
    load = 1'b0;
    check_eq("t4_fd", {31'b0, frame_done}, 32'h1);
    check_eq("t4_busy", {31'b0, busy}, 32'h0);

    // 5: disable during SHOW of digit 2
    while (k < 147) tick();
    check_eq("t5_idx2", {28'b0, dig_en}, 32'h4);
    en = 1'b0;
    tick();
    check_eq("t5_off", {28'b0, dig_en}, 32'h0);
    bad_en = 0; bad_fd = 0;
    repeat (15) begin
      tick();
      if (dig_en != 4'b0) bad_en++;
      if (frame_done) bad_fd++;
    end
    check_eq("t5_idle_en", bad_en, 0);
    check_eq("t5_idle_fd", bad_fd, 0);
    push_slots(VC, 0, 3);
    en = 1'b1;
    sync0();
    run_frame(first_en, zeros, fd_k, fd_cnt);
    check_eq("t5_restart_first_en", first_en, 2);
    check_eq("t5_restart_fd_k", fd_k, 32);

    // 6: asynchronous reset between clock edges mid-SHOW
    load = 1'b1; digit_val = V1;
    tick();
    load = 1'b0;
    check_eq("t6_busy_set", {31'b0, busy}, 32'h1);
    push_slots(VC, 0, 0);
    while (k < 36) tick();
    #2;
    reset = 1'b1;
    #1;
    check_eq("t6_rst_dig_en", {28'b0, dig_en}, 32'h0);
    check_eq("t6_rst_code", {27'b0, code_out}, 32'h0);
    check_eq("t6_rst_busy", {31'b0, busy}, 32'h0);
    check_eq("t6_sb_empty", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_slots(20'h0, 0, 3);
    sync0();
    run_frame(first_en, zeros, fd_k, fd_cnt);
    check_eq("t6_first_en", first_en, 2);
    check_eq("t6_fd_k", fd_k, 32);
    check_eq("t6_busy", {31'b0, busy}, 32'h0);

    en = 1'b0;
    repeat (3) tick();
    check_eq("sb_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
